pong_match_controller: RTL and testbench

Match-level scoring and serve controller for the pong game. It replaces single-point scoring with a parametrised match FSM: goal detection at configurable field edges, exactly one point per goal, a ball-hold serve delay, a configurable winning score and game-over/restart handling. It sits between the ball position logic, which supplies `x_ball` and honours `ball_hold`, and the score/HUD rendering, which consumes the scores, `winner` and `game_over`.

---
 rtl/pong_match_controller.sv | 168 ++++++++++++++++
 tb/tb_pong_match_controller.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_match_controller.sv
// Match-level scoring and serve controller for pong: goal detection, per-player
// scores, serve hold delay, winning score and game-over/restart handling.
module pong_match_controller #(
    parameter int unsigned X_GOAL_L    = 30,
    parameter int unsigned X_GOAL_R    = 972,
    parameter int unsigned SCORE_W     = 4,
    parameter int unsigned WIN_SCORE   = 9,
    parameter int unsigned SERVE_DELAY = 60
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               timing_tick,
    input  logic [10:0]        x_ball,
    input  logic               start,
    output logic [SCORE_W-1:0] player1_score,
    output logic [SCORE_W-1:0] player2_score,
    output logic               goal_p1,
    output logic               goal_p2,
    output logic               ball_hold,
    output logic [1:0]         last_scorer,
    output logic               game_over,
    output logic [1:0]         winner
);

    localparam int unsigned X_W   = 11;
    localparam int unsigned CNT_W = (SERVE_DELAY == 0) ? 1 : $clog2(SERVE_DELAY + 1);

    localparam logic [X_W-1:0]     GOAL_L  = X_W'(X_GOAL_L);
    localparam logic [X_W-1:0]     GOAL_R  = X_W'(X_GOAL_R);
    localparam logic [SCORE_W-1:0] WIN     = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   DELAY   = CNT_W'(SERVE_DELAY);
    localparam logic [1:0]         WHO_P1  = 2'b01;
    localparam logic [1:0]         WHO_P2  = 2'b10;
    localparam logic [1:0]         WHO_NONE = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_HOLD,
        S_GAME_OVER
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   serve_cnt;
    logic [CNT_W-1:0]   serve_cnt_nxt;
    logic [SCORE_W-1:0] p1_nxt;
    logic [SCORE_W-1:0] p2_nxt;
    logic               goal_p1_nxt;
    logic               goal_p2_nxt;
    logic               hold_nxt;
    logic [1:0]         last_nxt;
    logic               over_nxt;
    logic [1:0]         winner_nxt;

    logic               out_left;
    logic               out_right;
    logic               in_field;
    logic               p1_won;
    logic               p2_won;

    assign out_left  = (x_ball < GOAL_L);
    assign out_right = (x_ball > GOAL_R);
    assign in_field  = !out_left && !out_right;
    assign p1_won    = (player1_score == WIN);
    assign p2_won    = (player2_score == WIN);

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            serve_cnt     <= '0;
            player1_score <= '0;
            player2_score <= '0;
            goal_p1       <= 1'b0;
            goal_p2       <= 1'b0;
            ball_hold     <= 1'b1;
            last_scorer   <= WHO_NONE;
            game_over     <= 1'b0;
            winner        <= WHO_NONE;
        end else begin
            state         <= state_nxt;
            serve_cnt     <= serve_cnt_nxt;
            player1_score <= p1_nxt;
            player2_score <= p2_nxt;
            goal_p1       <= goal_p1_nxt;
            goal_p2       <= goal_p2_nxt;
            ball_hold     <= hold_nxt;
            last_scorer   <= last_nxt;
            game_over     <= over_nxt;
            winner        <= winner_nxt;
        end
    end

    // Next-state and next-output logic; decisions only on tick cycles
    always_comb begin
        state_nxt     = state;
        serve_cnt_nxt = serve_cnt;
        p1_nxt        = player1_score;
        p2_nxt        = player2_score;
        goal_p1_nxt   = 1'b0;
        goal_p2_nxt   = 1'b0;
        hold_nxt      = ball_hold;
        last_nxt      = last_scorer;
        over_nxt      = game_over;
        winner_nxt    = winner;

        if (timing_tick) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nxt = S_PLAY;
                        hold_nxt  = 1'b0;
                    end
                end

                S_PLAY: begin
                    if (out_left) begin
                        p2_nxt        = player2_score + SCORE_W'(1);
                        goal_p2_nxt   = 1'b1;
                        last_nxt      = WHO_P2;
                        hold_nxt      = 1'b1;
                        serve_cnt_nxt = '0;
                        state_nxt     = S_HOLD;
                    end else if (out_right) begin
                        p1_nxt        = player1_score + SCORE_W'(1);
                        goal_p1_nxt   = 1'b1;
                        last_nxt      = WHO_P1;
                        hold_nxt      = 1'b1;
                        serve_cnt_nxt = '0;
                        state_nxt     = S_HOLD;
                    end
                end

                S_HOLD: begin
                    // A winning score ends the match before any serve
                    if (p1_won || p2_won) begin
                        state_nxt  = S_GAME_OVER;
                        over_nxt   = 1'b1;
                        winner_nxt = p1_won ? WHO_P1 : WHO_P2;
                    end else if ((serve_cnt >= DELAY) && in_field) begin
                        state_nxt = S_PLAY;
                        hold_nxt  = 1'b0;
                    end else if (serve_cnt < DELAY) begin
                        serve_cnt_nxt = serve_cnt + CNT_W'(1);
                    end
                end

                S_GAME_OVER: begin
                    if (start) begin
                        p1_nxt     = '0;
                        p2_nxt     = '0;
                        winner_nxt = WHO_NONE;
                        last_nxt   = WHO_NONE;
                        over_nxt   = 1'b0;
                        hold_nxt   = 1'b0;
                        state_nxt  = S_PLAY;
                    end
                end

                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_match_controller.sv
// Self-checking bench for pong_match_controller: two instances (default-like
// and 5-bit/21-point) checked by directed scenarios and a random run.
module tb_pong_match_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_rst   [2];
    logic        i_tick  [2];
    logic        i_start [2];
    logic [10:0] i_x     [2];

    logic [3:0]  a_p1, a_p2;
    logic [4:0]  b_p1, b_p2;
    logic [4:0]  o_p1    [2];
    logic [4:0]  o_p2    [2];
    logic        o_g1    [2];
    logic        o_g2    [2];
    logic        o_hold  [2];
    logic        o_over  [2];
    logic [1:0]  o_last  [2];
    logic [1:0]  o_win   [2];

    assign o_p1[0] = {1'b0, a_p1};
    assign o_p2[0] = {1'b0, a_p2};
    assign o_p1[1] = b_p1;
    assign o_p2[1] = b_p2;

    pong_match_controller #(.SERVE_DELAY(3)) dut_a (
        .clk(clk), .rst(i_rst[0]), .timing_tick(i_tick[0]), .x_ball(i_x[0]), .start(i_start[0]),
        .player1_score(a_p1), .player2_score(a_p2), .goal_p1(o_g1[0]), .goal_p2(o_g2[0]),
        .ball_hold(o_hold[0]), .last_scorer(o_last[0]), .game_over(o_over[0]), .winner(o_win[0])
    );

    pong_match_controller #(.SCORE_W(5), .WIN_SCORE(21), .SERVE_DELAY(0)) dut_b (
        .clk(clk), .rst(i_rst[1]), .timing_tick(i_tick[1]), .x_ball(i_x[1]), .start(i_start[1]),
        .player1_score(b_p1), .player2_score(b_p2), .goal_p1(o_g1[1]), .goal_p2(o_g2[1]),
        .ball_hold(o_hold[1]), .last_scorer(o_last[1]), .game_over(o_over[1]), .winner(o_win[1])
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: match flags plus a count of hold ticks seen
    int cfg_win [2] = '{9, 21};
    int cfg_d   [2] = '{3, 0};
    int m_p1 [2], m_p2 [2], m_last [2], m_win [2], m_seen [2];
    bit m_g1 [2], m_g2 [2], m_hold [2], m_over [2], m_active [2];

    task automatic model_step(input int j);
        int x;
        x = int'(i_x[j]);
        m_g1[j] = 1'b0;
        m_g2[j] = 1'b0;
        if (i_rst[j]) begin
            m_p1[j] = 0; m_p2[j] = 0; m_last[j] = 0; m_win[j] = 0; m_seen[j] = 0;
            m_hold[j] = 1'b1; m_over[j] = 1'b0; m_active[j] = 1'b0;
        end else if (i_tick[j]) begin
            if (!m_active[j]) begin
                if (i_start[j]) begin
                    m_active[j] = 1'b1;
                    m_hold[j] = 1'b0;
                end
            end else if (m_over[j]) begin
                if (i_start[j]) begin
                    m_p1[j] = 0; m_p2[j] = 0; m_last[j] = 0; m_win[j] = 0;
                    m_over[j] = 1'b0; m_hold[j] = 1'b0;
                end
            end else if (m_hold[j]) begin
                m_seen[j]++;
                if (m_p1[j] == cfg_win[j] || m_p2[j] == cfg_win[j]) begin
                    m_over[j] = 1'b1;
                    m_win[j] = (m_p1[j] == cfg_win[j]) ? 1 : 2;
                end else if (m_seen[j] > cfg_d[j] && x >= 30 && x <= 972) begin
                    m_hold[j] = 1'b0;
                end
            end else if (x < 30) begin
                m_p2[j]++; m_g2[j] = 1'b1; m_last[j] = 2; m_hold[j] = 1'b1; m_seen[j] = 0;
            end else if (x > 972) begin
                m_p1[j]++; m_g1[j] = 1'b1; m_last[j] = 1; m_hold[j] = 1'b1; m_seen[j] = 0;
            end
        end
    endtask

    // One clock cycle on instance k; the other instance sees no tick
    task automatic cyc(input int k, input bit r, input bit t, input int x, input bit s);
        i_rst[k] = r; i_tick[k] = t; i_x[k] = 11'(x); i_start[k] = s;
        i_rst[1-k] = 1'b0; i_tick[1-k] = 1'b0; i_start[1-k] = 1'b0;
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
    endtask

    // Drive in-field ticks until the model releases the serve or ends the match
    task automatic release_serve(input int k);
        for (int n = 0; n < 30 && m_hold[k] && !m_over[k]; n++) cyc(k, 0, 1, 500, 0);
    endtask

    task automatic test_reset;
        cyc(1, 1, 0, 500, 0);
        cyc(0, 1, 1, 500, 1);
        cyc(0, 1, 0, 500, 1);
        n_cmp++; if (o_p1[0] !== 5'd0) begin n_err++; $display("FAIL reset_p1: got %0d want 0", o_p1[0]); end
        n_cmp++; if (o_p2[0] !== 5'd0) begin n_err++; $display("FAIL reset_p2: got %0d want 0", o_p2[0]); end
        n_cmp++; if (o_hold[0] !== 1'b1) begin n_err++; $display("FAIL reset_hold: got %0d want 1", o_hold[0]); end
        n_cmp++; if (o_over[0] !== 1'b0) begin n_err++; $display("FAIL reset_over: got %0d want 0", o_over[0]); end
        n_cmp++; if (o_win[0] !== 2'b00) begin n_err++; $display("FAIL reset_winner: got %0d want 0", o_win[0]); end
        n_cmp++; if (o_last[0] !== 2'b00) begin n_err++; $display("FAIL reset_last: got %0d want 0", o_last[0]); end
        cyc(0, 0, 0, 500, 0);
        n_cmp++; if (o_hold[0] !== 1'b1) begin n_err++; $display("FAIL start_in_reset: got %0d want 1", o_hold[0]); end
        cyc(0, 0, 1, 500, 1);
        n_cmp++; if (o_hold[0] !== 1'b0) begin n_err++; $display("FAIL start_hold: got %0d want 0", o_hold[0]); end
    endtask

    task automatic test_left_goal;
        int pulses;
        cyc(0, 1, 0, 500, 0);
        cyc(0, 0, 1, 500, 1);
        cyc(0, 0, 1, 10, 0);
        n_cmp++; if (o_p2[0] !== 5'd1) begin n_err++; $display("FAIL left_p2: got %0d want 1", o_p2[0]); end
        n_cmp++; if (o_p1[0] !== 5'd0) begin n_err++; $display("FAIL left_p1: got %0d want 0", o_p1[0]); end
        n_cmp++; if (o_g2[0] !== 1'b1) begin n_err++; $display("FAIL left_pulse: got %0d want 1", o_g2[0]); end
        n_cmp++; if (o_last[0] !== 2'b10) begin n_err++; $display("FAIL left_last: got %0d want 2", o_last[0]); end
        n_cmp++; if (o_hold[0] !== 1'b1) begin n_err++; $display("FAIL left_hold: got %0d want 1", o_hold[0]); end
        cyc(0, 0, 0, 10, 0);
        n_cmp++; if (o_g2[0] !== 1'b0) begin n_err++; $display("FAIL left_pulse_width: got %0d want 0", o_g2[0]); end
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 3) == 0) cyc(0, 0, 0, 10, 0);
            cyc(0, 0, 1, 10, 0);
            if (o_g2[0] === 1'b1) pulses++;
        end
        n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL linger_pulses: got %0d want 0", pulses); end
        n_cmp++; if (o_p2[0] !== 5'd1) begin n_err++; $display("FAIL linger_p2: got %0d want 1", o_p2[0]); end
        n_cmp++; if (o_hold[0] !== 1'b1) begin n_err++; $display("FAIL linger_hold: got %0d want 1", o_hold[0]); end
    endtask

    task automatic test_serve_delay;
        cyc(0, 1, 0, 500, 0);
        cyc(0, 0, 1, 500, 1);
        cyc(0, 0, 1, 990, 0);
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 0, 0, 500, 0);
            n_cmp++; if (o_hold[0] !== 1'b1) begin n_err++; $display("FAIL serve_notick_%0d: got %0d want 1", i, o_hold[0]); end
            cyc(0, 0, 1, 500, 0);
            n_cmp++; if (o_hold[0] !== ((i < 4) ? 1'b1 : 1'b0)) begin
                n_err++; $display("FAIL serve_tick_%0d: got %0d want %0d", i, o_hold[0], (i < 4) ? 1 : 0);
            end
        end
        cyc(0, 0, 1, 10, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 1, 990, 0);
            n_cmp++; if (o_hold[0] !== 1'b1) begin n_err++; $display("FAIL serve_ball_out_%0d: got %0d want 1", i, o_hold[0]); end
        end
        n_cmp++; if (o_p1[0] !== 5'd1 || o_p2[0] !== 5'd1) begin
            n_err++; $display("FAIL serve_out_scores: got %0d:%0d want 1:1", o_p1[0], o_p2[0]);
        end
        cyc(0, 0, 1, 500, 0);
        n_cmp++; if (o_hold[0] !== 1'b0) begin n_err++; $display("FAIL serve_recentre: got %0d want 0", o_hold[0]); end
    endtask

    task automatic test_winning;
        cyc(0, 1, 0, 500, 0);
        cyc(0, 0, 1, 500, 1);
        for (int i = 1; i <= 9; i++) begin
            cyc(0, 0, 1, 990, 0);
            n_cmp++; if (o_p1[0] !== 5'(i) || o_g1[0] !== 1'b1) begin
                n_err++; $display("FAIL win_goal_%0d: got score %0d pulse %0d want %0d 1", i, o_p1[0], o_g1[0], i);
            end
            if (i < 9) begin
                release_serve(0);
                n_cmp++; if (o_hold[0] !== 1'b0) begin n_err++; $display("FAIL win_release_%0d: got %0d want 0", i, o_hold[0]); end
            end
        end
        n_cmp++; if (o_over[0] !== 1'b0) begin n_err++; $display("FAIL win_over_early: got %0d want 0", o_over[0]); end
        cyc(0, 0, 0, 990, 0);
        n_cmp++; if (o_over[0] !== 1'b0) begin n_err++; $display("FAIL win_over_notick: got %0d want 0", o_over[0]); end
        cyc(0, 0, 1, 990, 0);
        n_cmp++; if (o_over[0] !== 1'b1) begin n_err++; $display("FAIL win_over: got %0d want 1", o_over[0]); end
        n_cmp++; if (o_win[0] !== 2'b01) begin n_err++; $display("FAIL win_winner: got %0d want 1", o_win[0]); end
        cyc(0, 0, 1, 10, 0);
        n_cmp++; if (o_p1[0] !== 5'd9 || o_p2[0] !== 5'd0 || o_g2[0] !== 1'b0) begin
            n_err++; $display("FAIL win_frozen: got %0d:%0d pulse %0d want 9:0 0", o_p1[0], o_p2[0], o_g2[0]);
        end
        cyc(0, 0, 1, 500, 1);
        n_cmp++; if (o_p1[0] !== 5'd0 || o_p2[0] !== 5'd0) begin
            n_err++; $display("FAIL restart_scores: got %0d:%0d want 0:0", o_p1[0], o_p2[0]);
        end
        n_cmp++; if (o_over[0] !== 1'b0 || o_win[0] !== 2'b00 || o_last[0] !== 2'b00 || o_hold[0] !== 1'b0) begin
            n_err++; $display("FAIL restart_flags: got over %0d win %0d last %0d hold %0d want 0 0 0 0",
                              o_over[0], o_win[0], o_last[0], o_hold[0]);
        end
    endtask

    task automatic test_reset_mid;
        cyc(0, 1, 0, 500, 0);
        cyc(0, 0, 1, 500, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, (i % 2 == 0) ? 990 : 10, 0);
            if (i < 4) release_serve(0);
        end
        n_cmp++; if (o_p1[0] !== 5'd3 || o_p2[0] !== 5'd2 || o_hold[0] !== 1'b1) begin
            n_err++; $display("FAIL mid_setup: got %0d:%0d hold %0d want 3:2 1", o_p1[0], o_p2[0], o_hold[0]);
        end
        cyc(0, 1, 1, 500, 0);
        n_cmp++; if (o_p1[0] !== 5'd0 || o_p2[0] !== 5'd0 || o_g1[0] !== 1'b0 || o_g2[0] !== 1'b0) begin
            n_err++; $display("FAIL mid_reset: got %0d:%0d pulses %0d%0d want 0:0 00", o_p1[0], o_p2[0], o_g1[0], o_g2[0]);
        end
        cyc(0, 0, 1, 10, 0);
        n_cmp++; if (o_p2[0] !== 5'd0 || o_hold[0] !== 1'b1 || o_last[0] !== 2'b00) begin
            n_err++; $display("FAIL mid_idle: got p2 %0d hold %0d last %0d want 0 1 0", o_p2[0], o_hold[0], o_last[0]);
        end
    endtask

    task automatic test_params;
        int changed;
        cyc(1, 1, 0, 500, 0);
        cyc(1, 0, 1, 500, 1);
        changed = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(1, 0, 0, ($urandom_range(0, 1) == 0) ? 5 : 1500, 0);
            if (o_p1[1] !== 5'd0 || o_p2[1] !== 5'd0 || o_hold[1] !== 1'b0 || o_g1[1] !== 1'b0 || o_g2[1] !== 1'b0) changed++;
        end
        n_cmp++; if (changed != 0) begin n_err++; $display("FAIL gated_tick: got %0d changed cycles want 0", changed); end
        for (int i = 0; i <= 40; i++) begin
            cyc(1, 0, 1, (i % 2 == 0) ? 990 : 10, 0);
            if (i < 40) begin
                cyc(1, 0, 1, 500, 0);
                if (i == 0) begin
                    n_cmp++; if (o_hold[1] !== 1'b0) begin n_err++; $display("FAIL d0_release: got %0d want 0", o_hold[1]); end
                end
            end
        end
        n_cmp++; if (o_p1[1] !== 5'd21 || o_p2[1] !== 5'd20 || o_over[1] !== 1'b0) begin
            n_err++; $display("FAIL p21_score: got %0d:%0d over %0d want 21:20 0", o_p1[1], o_p2[1], o_over[1]);
        end
        cyc(1, 0, 1, 990, 0);
        n_cmp++; if (o_over[1] !== 1'b1 || o_win[1] !== 2'b01) begin
            n_err++; $display("FAIL p21_winner: got over %0d win %0d want 1 1", o_over[1], o_win[1]);
        end
    endtask

    task automatic test_random;
        int k, r, x;
        for (int n = 0; n < 3000; n++) begin
            k = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1:    x = int'($urandom_range(0, 29));
                2, 3:    x = int'($urandom_range(973, 2047));
                4:       x = (int'($urandom_range(0, 1)) == 0) ? 29 + int'($urandom_range(0, 1)) : 972 + int'($urandom_range(0, 1));
                default: x = int'($urandom_range(30, 972));
            endcase
            cyc(k, $urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, x, $urandom_range(0, 3) == 0);
            for (int j = 0; j < 2; j++) begin
                n_cmp++; if (o_p1[j] !== 5'(m_p1[j]) || o_p2[j] !== 5'(m_p2[j])) begin
                    n_err++; $display("FAIL rand_score[%0d] @%0d: got %0d:%0d want %0d:%0d", j, n, o_p1[j], o_p2[j], m_p1[j], m_p2[j]);
                end
                n_cmp++; if (o_g1[j] !== m_g1[j] || o_g2[j] !== m_g2[j]) begin
                    n_err++; $display("FAIL rand_pulse[%0d] @%0d: got %0d%0d want %0d%0d", j, n, o_g1[j], o_g2[j], m_g1[j], m_g2[j]);
                end
                n_cmp++; if (o_hold[j] !== m_hold[j] || o_over[j] !== m_over[j]) begin
                    n_err++; $display("FAIL rand_flags[%0d] @%0d: got hold %0d over %0d want %0d %0d", j, n, o_hold[j], o_over[j], m_hold[j], m_over[j]);
                end
                n_cmp++; if (o_last[j] !== 2'(m_last[j]) || o_win[j] !== 2'(m_win[j])) begin
                    n_err++; $display("FAIL rand_who[%0d] @%0d: got last %0d win %0d want %0d %0d", j, n, o_last[j], o_win[j], m_last[j], m_win[j]);
                end
            end
        end
    endtask

    initial begin
        for (int j = 0; j < 2; j++) begin
            i_rst[j] = 1'b1; i_tick[j] = 1'b0; i_start[j] = 1'b0; i_x[j] = 11'd500;
        end
        @(negedge clk);
        test_reset;
        test_left_goal;
        test_serve_delay;
        test_winning;
        test_reset_mid;
        test_params;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
